// File: rtl/iterative_divider.sv
// Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// Handshakes: a transfer happens on a rising edge where valid && ready; i_ready is high only in IDLE, o_valid only in DONE.
module iterative_divider #(
  parameter int DATAWIDTH   = 4,
  parameter int INSTANCE_ID = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [2*DATAWIDTH-1:0] Z,
  input  logic [DATAWIDTH-1:0]   D,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [DATAWIDTH-1:0]   Q,
  output logic [DATAWIDTH-1:0]   R,
  output logic                   o_div_by_zero,
  output logic                   o_overflow
);

  localparam int W  = DATAWIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_n;
  logic [W:0]      p, p_n;
  logic [W-1:0]    s, s_n;
  logic [W-1:0]    d_reg, d_reg_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [W-1:0]    q_n, r_n;
  logic            dbz_n, ovf_n;
  logic [W:0]      shifted, t;

  assign i_ready = (state == IDLE);
  assign o_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      p             <= '0;
      s             <= '0;
      d_reg         <= '0;
      cnt           <= '0;
      Q             <= '0;
      R             <= '0;
      o_div_by_zero <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      state         <= state_n;
      p             <= p_n;
      s             <= s_n;
      d_reg         <= d_reg_n;
      cnt           <= cnt_n;
      Q             <= q_n;
      R             <= r_n;
      o_div_by_zero <= dbz_n;
      o_overflow    <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    p_n     = p;
    s_n     = s;
    d_reg_n = d_reg;
    cnt_n   = cnt;
    q_n     = Q;
    r_n     = R;
    dbz_n   = o_div_by_zero;
    ovf_n   = o_overflow;
    // Since P < D throughout, a borrow out of the W+1-bit subtraction means the trial failed.
    shifted = {p[W-1:0], s[W-1]};
    t       = shifted - {1'b0, d_reg};

    case (state)
      IDLE: begin
        if (i_valid) begin
          d_reg_n = D;
          if (D == '0) begin
            state_n = DONE;
            q_n     = '1;
            r_n     = Z[W-1:0];
            dbz_n   = 1'b1;
            ovf_n   = 1'b0;
          end else if (Z[2*W-1:W] >= D) begin
            state_n = DONE;
            q_n     = '1;
            r_n     = '0;
            dbz_n   = 1'b0;
            ovf_n   = 1'b1;
          end else begin
            state_n = CALC;
            p_n     = {1'b0, Z[2*W-1:W]};
            s_n     = Z[W-1:0];
            cnt_n   = CW'(W);
            dbz_n   = 1'b0;
            ovf_n   = 1'b0;
          end
        end
      end
      CALC: begin
        p_n   = t[W] ? shifted : t;
        s_n   = {s[W-2:0], ~t[W]};
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state_n = DONE;
          q_n     = s_n;
          r_n     = p_n[W-1:0];
        end
      end
      DONE: begin
        if (o_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Bench for iterative_divider (DATAWIDTH=4): directed cases, backpressure, async reset, round trip and random.
module tb_iterative_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0;
  logic       i_ready;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       o_valid;
  logic       o_ready = 1'b1;
  logic [3:0] q;
  logic [3:0] r;
  logic       dbz;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  bit rt_done;

  iterative_divider #(.DATAWIDTH(4), .INSTANCE_ID(0)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
    .Z(dividend), .D(divisor), .o_valid(o_valid), .o_ready(o_ready),
    .Q(q), .R(r), .o_div_by_zero(dbz), .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division plus the two exception rules.
  function automatic logic [9:0] model(input logic [7:0] z, input logic [3:0] d);
    int zi, di;
    zi = z;
    di = d;
    if (di == 0) return {4'hF, z[3:0], 1'b1, 1'b0};
    if ((zi / 16) >= di) return {4'hF, 4'h0, 1'b0, 1'b1};
    return {4'(zi / di), 4'(zi % di), 1'b0, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (!rst && o_valid && o_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", 1, 0);
      else check("scoreboard", {22'd0, q, r, dbz, ovf}, {22'd0, exp_q.pop_front()});
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!i_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!i_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] z, input logic [3:0] d, input bit push);
    wait_ready();
    i_valid  = 1'b1;
    dividend = z;
    divisor  = d;
    if (push) exp_q.push_back(model(z, d));
    @(posedge clk); #1;
    i_valid  = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!o_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=%0d exp=%0d", checks, 0);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [7:0] z;
    logic [3:0] d;

    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", o_valid, 0);
    check("rst_qr", {q, r}, 0);
    check("rst_flags", {dbz, ovf}, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rst_i_ready", i_ready, 1);

    // Normal case: latency W+1 and a one-cycle pulse
    send(8'h8F, 4'h9, 1);
    check("busy_i_ready", i_ready, 0);
    wait_valid(n);
    check("lat_normal", n, 5);
    check("t1_qr", {q, r}, 8'hF8);
    check("t1_flags", {dbz, ovf}, 0);
    @(posedge clk); #1;
    check("t1_pulse", o_valid, 0);
    check("t1_ready_back", i_ready, 1);

    send(8'h64, 4'h7, 1);
    wait_valid(n);
    check("t2_qr", {q, r}, 8'hE2);
    @(posedge clk); #1;
    send(8'h37, 4'h0, 1);
    wait_valid(n);
    check("lat_dbz", n, 1);
    check("dbz_qr", {q, r}, 8'hF7);
    check("dbz_flags", {dbz, ovf}, 2'b10);
    @(posedge clk); #1;

    send(8'h90, 4'h9, 1);
    wait_valid(n);
    check("lat_ovf", n, 1);
    check("ovf_qr", {q, r}, 8'hF0);
    check("ovf_flags", {dbz, ovf}, 2'b01);
    @(posedge clk); #1;
    send(8'h8F, 4'h9, 1);
    wait_valid(n);
    check("post_ovf_lat", n, 5);
    check("post_ovf_qr", {q, r}, 8'hF8);
    check("post_ovf_flags", {dbz, ovf}, 0);
    @(posedge clk); #1;

    // Backpressure: result held, extra request ignored
    o_ready = 1'b0;
    send(8'h64, 4'h7, 1);
    wait_valid(n);
    for (int k = 0; k < 3; k++) begin
      i_valid  = (k == 0);
      dividend = 8'h10;
      divisor  = 4'h2;
      check("bp_valid", o_valid, 1);
      check("bp_qr", {q, r}, 8'hE2);
      check("bp_i_ready", i_ready, 0);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    check("bp_hold", o_valid, 1);
    o_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", i_ready, 1);
    check("bp_release_valid", o_valid, 0);

    // Asynchronous reset mid-computation
    send(8'h2A, 4'h6, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_qr", {q, r}, 0);
    check("arst_flags", {dbz, ovf}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("arst_no_output", o_valid, 0);
    send(8'h2A, 4'h6, 1);
    wait_valid(n);
    check("arst_after_qr", {q, r}, 8'h70);
    @(posedge clk); #1;

    // Round trip with random backpressure
    rt_done = 1'b0;
    fork
      begin
        for (int a = 1; a < 16; a++)
          for (int b = 1; b < 16; b++)
            send(8'(a * b), 4'(b), 1);
        rt_done = 1'b1;
      end
      begin
        while (!rt_done) begin
          @(posedge clk); #1;
          o_ready = 1'($urandom_range(0, 1));
        end
        o_ready = 1'b1;
      end
    join

    // Random operands, half biased into the non-overflow range
    for (int i = 0; i < 60; i++) begin
      d = 4'($urandom_range(0, 15));
      if (i % 2 == 0 && d != 0) z = {4'($urandom_range(0, int'(d) - 1)), 4'($urandom)};
      else z = 8'($urandom);
      send(z, d, 1);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iterative_divider.md
Name: iterative_divider

Overview:
- Sequential unsigned restoring divider; the inverse of the array multiplier datapath.
- Takes a 2*DATAWIDTH dividend (a multiplier-width product) and a DATAWIDTH divisor, and returns a DATAWIDTH quotient and remainder.
- Produces one quotient bit per cycle, with valid/ready handshakes on both sides.
- Sits downstream of the multiplier tops for round-trip checking and for normalisation paths.

Parameters:
- DATAWIDTH, 4, operand width; dividend is 2*DATAWIDTH, quotient/remainder are DATAWIDTH.
- INSTANCE_ID, 0, instance tag carried for tooling; no functional effect.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  dividend/divisor valid.
- i_ready  output  1  block can accept; high only in IDLE.
- Z  input  2*DATAWIDTH  unsigned dividend.
- D  input  DATAWIDTH  unsigned divisor.
- o_valid  output  1  result valid.
- o_ready  input  1  downstream accepts result.
- Q  output  DATAWIDTH  quotient.
- R  output  DATAWIDTH  remainder.
- o_div_by_zero  output  1  D was 0.
- o_overflow  output  1  quotient does not fit (Z[2W-1:W] >= D, D != 0).

Behaviour:
- Reset (async, any state): state=IDLE, o_valid=0, Q=0, R=0, both flags=0, iteration counter=0. In-flight operation is discarded and no result is emitted.
- i_ready = (state==IDLE), combinational from state. i_ready=1 in the first cycle after reset release.
- IDLE: when i_valid && i_ready at a rising edge, capture Z and D, then:
  - D==0: go to DONE. Q=all ones, R=Z[W-1:0], o_div_by_zero=1, o_overflow=0.
  - else Z[2W-1:W] >= D: go to DONE. Q=all ones, R=0, o_overflow=1, o_div_by_zero=0.
  - else: partial remainder P (W+1 bits) = {0, Z[2W-1:W]}, shift register S = Z[W-1:0], counter=W, flags cleared, go to CALC.
- CALC: once per cycle:
  - T = {P[W-1:0], S[W-1]} - D, computed at W+1 bits.
  - If T is non-negative: P=T and quotient bit = 1; else P={P[W-1:0], S[W-1]} and quotient bit = 0.
  - Shift the quotient bit into the LSB of S.
  - Decrement the counter. When it reaches 0, go to DONE with Q=S (updated) and R=P[W-1:0].
- DONE: o_valid=1. Q, R and both flags are held stable while o_valid && !o_ready. On o_valid && o_ready, go to IDLE and drop o_valid the next cycle.
- Latency, with the accept edge ending cycle 0:
  - normal: o_valid first high in cycle W+1;
  - exception: o_valid high in cycle 1.
- Minimum initiation interval: W+2 cycles normal, 2 cycles exception.
- i_valid while busy (CALC/DONE) is ignored; no capture occurs. Z and D need not be held after acceptance.
- Q/R/flags keep their last values after the DONE handshake until the next result loads; they are meaningful only while o_valid=1.
- All arithmetic is unsigned. No rounding.
- Invariant whenever o_valid && !flags: Z == Q*D + R and R < D.

Test Plan (DATAWIDTH=4):
- Z=0x8F, D=0x9, o_ready=1 -> i_ready drops after accept; o_valid in cycle 5 with Q=0xF, R=0x8, flags 0; one-cycle pulse.
- Z=0x64, D=0x7 -> Q=0xE, R=0x2; then Z=0x37, D=0x0 -> o_valid in cycle 1 with Q=0xF, R=0x7, o_div_by_zero=1.
- Z=0x90, D=0x9 -> o_overflow=1, Q=0xF, R=0x0, o_valid in cycle 1. Then Z=0x8F, D=0x9 -> overflow=0, result correct.
- Backpressure: Z=0x64, D=0x7 with o_ready=0 for 3 cycles after o_valid -> Q/R/o_valid stable, i_ready=0. Second i_valid (Z=0x10, D=0x2) during this window is not captured. o_ready=1 -> i_ready=1 next cycle.
- Reset asserted asynchronously in CALC (2 iterations done) -> o_valid, Q, R, flags go to 0 immediately with no output. After release, a new Z=0x2A, D=0x6 gives Q=0x7, R=0x0.
- Round trip: exhaustive A,B in 1..15, Z=A*B, D=B, random o_ready -> Q==A, R==0, flags 0, results in order, no lost or duplicated outputs.
